// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state encoding, stop constants and level-to-mask helper
package ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int MAX_STAGES = 32;
  localparam int MAX_LVL_W  = 5;

  // Thermometer mask with bits 0..level set; all zero when no candidate is valid.
  function automatic logic [MAX_STAGES-1:0] lvl_to_mask(input logic [MAX_LVL_W-1:0] level,
                                                       input logic                 valid);
    logic [MAX_STAGES-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      mask[i] = valid && (i <= int'(level));
    end
    return mask;
  endfunction

endpackage

// File: rtl/pipe_stall_mask.sv
// rtl/pipe_stall_mask.sv - deepest-request encoder, hold max-combine and thermometer stall mask
module pipe_stall_mask
  import ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 6,
  parameter int LVL_W      = $clog2(NUM_STAGES)
) (
  input  logic [NUM_STAGES-1:0] stallreq,
  input  logic                  hold_act,
  input  logic [LVL_W-1:0]      hold_lvl,
  input  logic                  force_off,
  output logic [NUM_STAGES-1:0] stall
);

  logic             req_valid;
  logic [LVL_W-1:0] req_lvl;
  logic [LVL_W-1:0] lvl;
  logic             valid;

  always_comb begin
    req_valid = |stallreq;
    req_lvl   = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stallreq[i]) req_lvl = LVL_W'(i);
    end
    lvl = req_lvl;
    if (hold_act && (!req_valid || (hold_lvl > req_lvl))) lvl = hold_lvl;
    valid = (req_valid || hold_act) && !force_off;
    stall = NUM_STAGES'(lvl_to_mask(MAX_LVL_W'(lvl), valid));
  end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// rtl/pipe_ctrl_gen.sv - pipeline stall/flush controller with timed hold, redirect and stall counter
module pipe_ctrl_gen
  import ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 6,
  parameter int ADDR_W     = 32,
  parameter int HOLD_W     = 6,
  parameter int PERF_W     = 32,
  parameter int LVL_W      = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq,
  input  logic                  hold_valid,
  input  logic [LVL_W-1:0]      hold_stage,
  input  logic [HOLD_W-1:0]     hold_len,
  input  logic                  flush_req,
  input  logic [ADDR_W-1:0]     flush_pc,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [ADDR_W-1:0]     new_pc,
  output logic                  busy,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam logic [LVL_W:0] STAGE_LIM = (LVL_W+1)'(NUM_STAGES);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [LVL_W-1:0]  hold_lvl_q, hold_lvl_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic              hold_ok;
  logic              hold_now;
  logic              mask_hold_act;
  logic [LVL_W-1:0]  mask_hold_lvl;
  logic              mask_off;

  always_comb begin
    hold_ok    = hold_valid && ({1'b0, hold_stage} < STAGE_LIM) && (hold_len != '0);
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_lvl_d = hold_lvl_q;
    pc_d       = pc_q;
    hold_now   = NO_STOP;
    case (state_q)
      RUN: begin
        if (flush_req) begin
          state_d = FLUSH;
          pc_d    = flush_pc;
        end else if (hold_ok) begin
          // The strobe cycle itself is the first hold cycle, so only len-1 remain.
          hold_now = STOP;
          if (hold_len > HOLD_W'(1)) begin
            state_d    = HOLD;
            cnt_d      = hold_len - HOLD_W'(1);
            hold_lvl_d = hold_stage;
          end
        end
      end
      HOLD: begin
        cnt_d = cnt_q - HOLD_W'(1);
        if (flush_req) begin
          state_d = FLUSH;
          pc_d    = flush_pc;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_W'(1)) begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (flush_req) pc_d = flush_pc;
        else           state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    flush_d       = (state_d == FLUSH);
    mask_hold_act = hold_now || (state_q == HOLD);
    mask_hold_lvl = (state_q == HOLD) ? hold_lvl_q : hold_stage;
    mask_off      = rst || (state_q == FLUSH);
    perf_d        = (stall[0] && (perf_q != '1)) ? perf_q + PERF_W'(1) : perf_q;
  end

  pipe_stall_mask #(
    .NUM_STAGES(NUM_STAGES),
    .LVL_W     (LVL_W)
  ) u_mask (
    .stallreq (stallreq),
    .hold_act (mask_hold_act),
    .hold_lvl (mask_hold_lvl),
    .force_off(mask_off),
    .stall    (stall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      hold_lvl_q <= '0;
      pc_q       <= '0;
      flush_q    <= 1'b0;
      perf_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_lvl_q <= hold_lvl_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      perf_q     <= perf_d;
    end
  end

  assign flush        = flush_q;
  assign new_pc       = pc_q;
  assign busy         = (state_q != RUN);
  assign stall_cycles = perf_q;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// tb/tb_pipe_ctrl_gen.sv - self-checking bench for pipe_ctrl_gen (default and 4-bit counter instances)
module tb_pipe_ctrl_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallreq;
  logic        hold_valid;
  logic [2:0]  hold_stage;
  logic [5:0]  hold_len;
  logic        flush_req;
  logic [31:0] flush_pc;

  logic [5:0]  stall, stall_s;
  logic        flush, flush_s, busy, busy_s;
  logic [31:0] new_pc, new_pc_s;
  logic [31:0] stall_cycles;
  logic [3:0]  stall_cycles_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl_gen dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .hold_valid(hold_valid),
    .hold_stage(hold_stage), .hold_len(hold_len), .flush_req(flush_req),
    .flush_pc(flush_pc), .stall(stall), .flush(flush), .new_pc(new_pc),
    .busy(busy), .stall_cycles(stall_cycles)
  );

  pipe_ctrl_gen #(.PERF_W(4)) dut_s (
    .clk(clk), .rst(rst), .stallreq(stallreq), .hold_valid(hold_valid),
    .hold_stage(hold_stage), .hold_len(hold_len), .flush_req(flush_req),
    .flush_pc(flush_pc), .stall(stall_s), .flush(flush_s), .new_pc(new_pc_s),
    .busy(busy_s), .stall_cycles(stall_cycles_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining hold cycles, flush flag, latched pc, stalled-cycle tally.
  int       m_rem = 0;
  int       m_hlvl = 0;
  bit       m_flush = 0;
  bit [31:0] m_pc = 0;
  longint   m_ctr = 0;
  bit       m_valid = 0;

  always @(negedge clk) begin
    int         lvl;
    bit         acc;
    logic [5:0] e_stall;
    acc = !rst && !m_flush && (m_rem == 0) && hold_valid && (hold_stage < 6) &&
          (hold_len != 0) && !flush_req;
    lvl = -1;
    for (int i = 0; i < 6; i++) if (stallreq[i]) lvl = i;
    if (m_rem > 0 && m_hlvl > lvl) lvl = m_hlvl;
    if (acc && int'(hold_stage) > lvl) lvl = int'(hold_stage);
    if (rst || m_flush) lvl = -1;
    for (int i = 0; i < 6; i++) e_stall[i] = (i <= lvl);

    if (m_valid || rst) begin
      chk("m_stall", stall, e_stall);
      chk("m_stall_s", stall_s, e_stall);
    end
    if (m_valid) begin
      chk("m_busy", busy, (m_rem > 0) || m_flush);
      chk("m_flush", flush, m_flush);
      if (m_flush) chk("m_new_pc", new_pc, m_pc);
      chk("m_cnt", stall_cycles, m_ctr);
      chk("m_cnt_s", stall_cycles_s, (m_ctr > 15) ? 15 : m_ctr);
    end

    if (rst) begin
      m_rem = 0; m_flush = 0; m_pc = 0; m_ctr = 0; m_valid = 1;
    end else begin
      if (e_stall[0]) m_ctr++;
      if (flush_req) begin
        m_flush = 1; m_pc = flush_pc; m_rem = 0;
      end else begin
        m_flush = 0;
        if (m_rem > 0) m_rem--;
        else if (acc) begin
          m_rem  = int'(hold_len) - 1;
          m_hlvl = int'(hold_stage);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; stallreq = 0; hold_valid = 0; hold_stage = 0; hold_len = 0;
    flush_req = 0; flush_pc = 0;
    step(); step();
    rst = 0; #1;
    chk("rst_stall", stall, 0); chk("rst_busy", busy, 0); chk("rst_flush", flush, 0);
    chk("rst_pc", new_pc, 0); chk("rst_cnt", stall_cycles, 0);

    step(); stallreq = 6'b001000; #1 chk("t1_ex", stall, 6'b001111);
    step(); stallreq = 6'b011000; #1 chk("t1_mem", stall, 6'b011111);
    step(); stallreq = 0;         #1 chk("t1_clear", stall, 0);

    step(); hold_valid = 1; hold_stage = 3; hold_len = 4;
    #1 chk("t2_strobe", stall, 6'b001111); chk("t2_busy0", busy, 0);
    for (int k = 0; k < 3; k++) begin
      step(); hold_valid = 0;
      #1 chk("t2_hold", stall, 6'b001111); chk("t2_busy", busy, 1);
    end
    step(); #1 chk("t2_end", stall, 0); chk("t2_end_busy", busy, 0);
    step(); hold_valid = 1; hold_len = 1; #1 chk("t2_len1", stall, 6'b001111);
    step(); hold_valid = 0; #1 chk("t2_len1_end", stall, 0); chk("t2_len1_busy", busy, 0);
    step(); hold_valid = 1; hold_len = 0; #1 chk("t2_len0", stall, 0);
    step(); hold_stage = 7; hold_len = 3; #1 chk("oor_stall", stall, 0);
    step(); hold_valid = 0; hold_stage = 0; hold_len = 0; #1 chk("oor_busy", busy, 0);

    step(); hold_valid = 1; hold_stage = 3; hold_len = 4; #1 chk("t3_strobe", stall, 6'b001111);
    step(); hold_valid = 0; stallreq = 6'b010000; #1 chk("t3_deep", stall, 6'b011111);
    step(); stallreq = 0; hold_valid = 1; hold_stage = 5; hold_len = 9;
    #1 chk("t3_ignore", stall, 6'b001111);
    step(); hold_valid = 0; #1 chk("t3_last", stall, 6'b001111); chk("t3_last_busy", busy, 1);
    step(); #1 chk("t3_end", stall, 0); chk("t3_end_busy", busy, 0);

    step(); hold_valid = 1; hold_stage = 3; hold_len = 6;
    step(); hold_valid = 0; flush_req = 1; flush_pc = 32'h100; #1 chk("t4_hold", stall, 6'b001111);
    step(); flush_req = 0; stallreq = 6'b000100;
    #1 chk("t4_flush", flush, 1); chk("t4_pc", new_pc, 32'h100); chk("t4_stall", stall, 0);
    step(); stallreq = 0;
    #1 chk("t4_after", flush, 0); chk("t4_after_stall", stall, 0); chk("t4_after_busy", busy, 0);

    step(); flush_req = 1; flush_pc = 32'h100;
    step(); flush_pc = 32'h200; #1 chk("t5_f1", flush, 1); chk("t5_pc1", new_pc, 32'h100);
    step(); flush_req = 0;      #1 chk("t5_f2", flush, 1); chk("t5_pc2", new_pc, 32'h200);
    step(); #1 chk("t5_f3", flush, 0);
    step(); flush_req = 1; flush_pc = 32'h300; hold_valid = 1; hold_stage = 2; hold_len = 3;
    #1 chk("t5_both_stall", stall, 0);
    step(); flush_req = 0; hold_valid = 0;
    #1 chk("t5_both_flush", flush, 1); chk("t5_both_pc", new_pc, 32'h300); chk("t5_both_st", stall, 0);
    step(); #1 chk("t5_nohold", busy, 0); chk("t5_nohold_st", stall, 0);

    step(); hold_valid = 1; hold_stage = 4; hold_len = 5;
    step(); hold_valid = 0; rst = 1; #1 chk("t6_rst_stall", stall, 0);
    step(); rst = 0;
    #1 chk("t6_busy", busy, 0); chk("t6_flush", flush, 0);
    chk("t6_cnt", stall_cycles, 0); chk("t6_stall", stall, 0);

    step(); stallreq = 6'b000001;
    repeat (9) step();
    step(); stallreq = 0;
    #1 chk("cnt10", stall_cycles, 10); chk("cnt10_s", stall_cycles_s, 10);
    step(); stallreq = 6'b000001;
    repeat (9) step();
    step(); stallreq = 0;
    #1 chk("cnt20", stall_cycles, 20); chk("cnt20_sat", stall_cycles_s, 15);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_gen.md
Name: pipe_ctrl_gen

Overview:
Parametrised pipeline stall/flush controller, the next generation of the fixed 6-stage stall controller. It sits beside the pipeline, takes per-stage stall requests, and drives a stall vector to the inter-stage registers.
- Stall priority is deepest-stage-wins.
- Adds a timed multi-cycle hold channel for fixed-latency units such as mul/div.
- Adds a registered flush with a redirect PC.
- Adds a saturating stall-cycle performance counter.

Parameters:
NUM_STAGES, 6, number of pipeline positions; index 0 = PC, NUM_STAGES-1 = WB.
ADDR_W, 32, width of flush_pc / new_pc.
HOLD_W, 6, width of hold_len.
PERF_W, 32, width of stall_cycles.
LVL_W, $clog2(NUM_STAGES), derived; stage-index width.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  reset; synchronous, active-high.
stallreq  in  NUM_STAGES  bit i = 1: stage i requests stall this cycle (level, combinational use).
hold_valid  in  1  one-cycle strobe: start a timed hold.
hold_stage  in  LVL_W  stage issuing the hold; values >= NUM_STAGES are ignored.
hold_len  in  HOLD_W  total hold length in cycles; 0 = ignored.
flush_req  in  1  one-cycle strobe: flush the pipeline and redirect.
flush_pc  in  ADDR_W  redirect target, sampled with flush_req.
stall  out  NUM_STAGES  stall[k:0] = 1 for the effective stall level k, else 0.
flush  out  1  registered flush pulse to all inter-stage registers.
new_pc  out  ADDR_W  redirect PC, valid while flush = 1.
busy  out  1  state != RUN.
stall_cycles  out  PERF_W  count of cycles with stall[0] = 1; saturates at all-ones.

Behaviour:
- Reset, checked at clk edge while rst = 1:
  - state = RUN; hold counter cnt = 0; held level = 0.
  - flush = 0, new_pc = 0, stall_cycles = 0.
  - stall = 0 combinationally while rst = 1.
  - Reset mid-HOLD or mid-FLUSH aborts immediately.
- Stall level, combinational:
  - req_lvl = highest i with stallreq[i] = 1.
  - hold_lvl = registered hold_stage while in HOLD, or the live hold_stage on an accepted hold_valid cycle.
  - Effective level = max of the valid candidates.
  - stall = thermometer mask with bits 0..level set; no candidate gives stall = 0.
  - Example with 6 stages: level 3 (EX) gives stall = 6'b001111.
- States RUN, HOLD, FLUSH:
  - RUN:
    - flush_req = 1: go to FLUSH and latch flush_pc. flush_req has priority over hold_valid in the same cycle.
    - else hold_valid = 1 with hold_len >= 2: go to HOLD, cnt = hold_len - 1, latch hold_stage.
    - hold_len = 1: stall for this cycle only, stay in RUN.
    - hold_len = 0: no effect.
  - HOLD:
    - Hold level is applied every cycle; cnt decrements.
    - When cnt = 1, the hold is applied this cycle, then go to RUN.
    - Total hold = exactly hold_len cycles, counting the strobe cycle.
    - hold_valid while in HOLD is ignored (no extension).
    - flush_req while in HOLD: go to FLUSH; the hold is aborted.
  - FLUSH, one cycle:
    - flush = 1, new_pc = latched pc.
    - stall forced to 0; stallreq is ignored this cycle.
    - Next state RUN.
    - flush_req = 1 during FLUSH: stay in FLUSH for another cycle and latch the new pc (back-to-back redirect).
- Latency:
  - flush and new_pc appear 1 cycle after flush_req (registered).
  - stall responds in the same cycle as its requests.
- Counter: increments on every non-reset cycle with stall[0] = 1; holds at 2^PERF_W - 1.
- Out-of-range stallreq bits cannot occur (vector width = NUM_STAGES).
- Out-of-range hold_stage: the strobe is ignored; state is unchanged.

Decomposition:
- Shared package `ctrl_pkg`: state encoding (RUN/HOLD/FLUSH), Stop/NoStop constants, and function `lvl_to_mask(level, valid)`.
- One sub-module, `pipe_stall_mask`: priority encoder plus max-combine plus thermometer mask, purely combinational, parametrised by NUM_STAGES.

Test Plan:
1. NUM_STAGES=6, stallreq = 6'b001000 (EX) -> stall = 6'b001111 same cycle. Then stallreq = 6'b011000 -> stall = 6'b011111 (deepest wins; MEM over EX).
2. hold_valid with hold_stage = 3, hold_len = 4, no stallreq -> stall = 6'b001111 for exactly 4 cycles (strobe cycle plus 3), then 0; busy = 1 for 3 cycles. Repeat with hold_len = 1 -> 1 cycle, busy stays 0. Repeat with hold_len = 0 -> no stall.
3. During HOLD (stage 3), stallreq = 6'b010000 -> stall = 6'b011111. A hold_valid with hold_len = 9 mid-hold -> ignored; the hold still ends on the original schedule.
4. flush_req with flush_pc = 32'h0000_0100 while in HOLD -> next cycle flush = 1, new_pc = 0x100, stall = 0 even with stallreq = 6'b000100. Following cycle: RUN, flush = 0, no residual hold.
5. flush_req on two consecutive cycles (pc 0x100, then 0x200) -> flush = 1 for 2 cycles with new_pc 0x100, then 0x200. flush_req and hold_valid together -> flush wins, hold dropped.
6. Reset asserted mid-HOLD -> at the next edge: state RUN, flush = 0, stall_cycles = 0, stall = 0 while rst = 1. Counter check: 10 stalled cycles -> stall_cycles = 10. With PERF_W = 4, 20 stalled cycles -> stall_cycles = 15 (saturated).
